// File: rtl/aes_core_arbiter_if.sv
// Host-side request/response channels of the shared AES core arbiter.
// master = requester side, slave = arbiter side.
interface aes_core_arbiter_if #(
    parameter int DATA_WIDTH = 128
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_op;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [DATA_WIDTH-1:0] req_key0;
    logic [DATA_WIDTH-1:0] req_key1;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_data0, req_data1, req_key0, req_key1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data0, req_data1, req_key0, req_key1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES encrypt/decrypt core between two requesters,
// sequencing the core start/done protocol with a watchdog that turns a hung core into an error.
module aes_core_arbiter #(
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_core_arbiter_if.slave     bus,
    output logic                  core_start_enc,
    output logic                  core_start_dec,
    output logic [DATA_WIDTH-1:0] core_din_enc,
    output logic [DATA_WIDTH-1:0] core_din_dec,
    output logic [DATA_WIDTH-1:0] core_key,
    input  logic [DATA_WIDTH-1:0] core_dout_enc,
    input  logic [DATA_WIDTH-1:0] core_dout_dec,
    input  logic                  core_done_enc,
    input  logic                  core_done_dec,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic                  rr_ptr;
    logic                  gnt_id;
    logic                  op_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] key_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic [1:0]            rsp_valid_r;
    logic                  rsp_err_r;
    logic [CNT_W-1:0]      wdog;

    logic                  pick;
    logic                  pick_vld;
    logic                  done_sel;
    logic [DATA_WIDTH-1:0] dout_sel;
    logic                  timeout_hit;

    // Round-robin choice: the pointed-to requester first, else the other one.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        if (bus.req_valid[rr_ptr]) begin
            pick     = rr_ptr;
            pick_vld = 1'b1;
        end else if (bus.req_valid[!rr_ptr]) begin
            pick     = !rr_ptr;
            pick_vld = 1'b1;
        end
    end

    // Ready is only offered in IDLE, so the request handshake completes in the grant cycle.
    assign bus.req_ready = (state == ST_IDLE && pick_vld && !rst) ? (2'b01 << pick) : 2'b00;

    // Only the done/dout pair of the latched operation is ever looked at.
    assign done_sel    = op_r ? core_done_dec : core_done_enc;
    assign dout_sel    = op_r ? core_dout_dec : core_dout_enc;
    assign timeout_hit = (wdog == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            rr_ptr         <= 1'b0;
            gnt_id         <= 1'b0;
            op_r           <= 1'b0;
            data_r         <= '0;
            key_r          <= '0;
            rsp_data_r     <= '0;
            rsp_valid_r    <= 2'b00;
            rsp_err_r      <= 1'b0;
            wdog           <= '0;
            core_start_enc <= 1'b0;
            core_start_dec <= 1'b0;
        end else begin
            core_start_enc <= 1'b0;
            core_start_dec <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        op_r           <= bus.req_op[pick];
                        data_r         <= pick ? bus.req_data1 : bus.req_data0;
                        key_r          <= pick ? bus.req_key1 : bus.req_key0;
                        gnt_id         <= pick;
                        rr_ptr         <= !pick;
                        core_start_enc <= !bus.req_op[pick];
                        core_start_dec <= bus.req_op[pick];
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the limit cycle still completes normally.
                    if (done_sel) begin
                        rsp_data_r  <= dout_sel;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 2'b01 << gnt_id;
                        state       <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 2'b01 << gnt_id;
                        state       <= ST_RESP;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[gnt_id]) begin
                        rsp_valid_r <= 2'b00;
                        rsp_err_r   <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign core_din_enc  = data_r;
    assign core_din_dec  = data_r;
    assign core_key      = key_r;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized scoreboard bench for aes_core_arbiter with a behavioural core model,
// a transaction-level arbitration/latency reference and an independent response monitor.
module tb_aes_core_arbiter;

    localparam int DW = 128;
    localparam int TO = 64;

    localparam logic [DW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_start_enc, core_start_dec;
    logic [DW-1:0] core_din_enc, core_din_dec, core_key;
    logic [DW-1:0] core_dout_enc, core_dout_dec;
    logic          core_done_enc, core_done_dec;
    logic          busy;

    aes_core_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    aes_core_arbiter #(
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .core_start_enc(core_start_enc),
        .core_start_dec(core_start_dec),
        .core_din_enc(core_din_enc),
        .core_din_dec(core_din_dec),
        .core_key(core_key),
        .core_dout_enc(core_dout_enc),
        .core_dout_dec(core_dout_dec),
        .core_done_enc(core_done_enc),
        .core_done_dec(core_done_dec),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          op;
        logic [DW-1:0] data;
        logic [DW-1:0] key;
        int            delay;   // core done this many cycles after start; 0 = never
        bit            wrong;   // pulse the other done one cycle after start
        bit            level;   // hold done high until the next start
    } req_t;

    typedef struct {
        int            gid;
        req_t          r;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    req_t rq[2][$];
    exp_t sb[$];
    exp_t sq[$];

    int passed = 0;
    int total  = 0;

    bit rr_m = 1'b0;
    bit busy_m = 1'b0;
    bit in_rsp = 1'b0;
    bit hold_prev = 1'b0;
    bit just_done = 1'b0;
    bit rsp_rand = 1'b0;
    int hold_cycles = 0;
    int hold_left = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stand-in cipher: the FIPS-197 C.1 vector plus an arbitrary invertible-looking mix.
    function automatic logic [DW-1:0] fenc(input logic [DW-1:0] d, input logic [DW-1:0] k);
        logic [DW-1:0] x;
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        x = d ^ k;
        return {x[DW-9:0], x[DW-1:DW-8]} ^ {4{32'h5a5ac3c3}};
    endfunction

    function automatic logic [DW-1:0] fdec(input logic [DW-1:0] d, input logic [DW-1:0] k);
        logic [DW-1:0] x;
        x = d + k;
        return ~x ^ {4{32'h0f1e2d3c}};
    endfunction

    // Transaction-level expectation: done inside the first TO wait cycles succeeds.
    function automatic exp_t predict(input int gid, input req_t r, input int acc);
        exp_t e;
        bit ok;
        ok     = (r.delay >= 1) && (r.delay <= TO);
        e.gid  = gid;
        e.r    = r;
        e.acc  = acc;
        e.err  = !ok;
        e.data = ok ? (r.op ? fdec(r.data, r.key) : fenc(r.data, r.key)) : '0;
        e.lat  = 2 + (ok ? r.delay : TO);
        return e;
    endfunction

    task automatic push(input int i, input logic op, input logic [DW-1:0] d, input logic [DW-1:0] k,
                        input int dl, input bit wr, input bit lv);
        req_t r;
        r.op = op; r.data = d; r.key = k; r.delay = dl; r.wrong = wr; r.level = lv;
        rq[i].push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_start"}, {core_start_enc, core_start_dec}, 0);
        chk({tag, "_din_enc"}, core_din_enc, 0);
        chk({tag, "_din_dec"}, core_din_dec, 0);
        chk({tag, "_key"}, core_key, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0 || sb.size() != 0 || busy_m) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        else passed++;
        repeat (2) @(negedge clk);
        #3;
    endtask

    // Request driver and arbitration reference.
    logic [1:0] d_exp, d_hs;
    int         d_pk, d_g;
    exp_t       d_e;
    initial begin
        bus.req_valid = 2'b00;
        bus.req_op    = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.req_key0  = '0;
        bus.req_key1  = '0;
        forever begin
            @(negedge clk);
            if (!rst && rq[0].size() != 0) begin
                bus.req_valid[0] = 1'b1; bus.req_op[0] = rq[0][0].op;
                bus.req_data0 = rq[0][0].data; bus.req_key0 = rq[0][0].key;
            end else begin
                bus.req_valid[0] = 1'b0; bus.req_op[0] = 1'($urandom);
                bus.req_data0 = rnd128(); bus.req_key0 = rnd128();
            end
            if (!rst && rq[1].size() != 0) begin
                bus.req_valid[1] = 1'b1; bus.req_op[1] = rq[1][0].op;
                bus.req_data1 = rq[1][0].data; bus.req_key1 = rq[1][0].key;
            end else begin
                bus.req_valid[1] = 1'b0; bus.req_op[1] = 1'($urandom);
                bus.req_data1 = rnd128(); bus.req_key1 = rnd128();
            end
            #1;
            if (!rst) begin
                d_pk = -1;
                if (!busy_m) begin
                    if (bus.req_valid[rr_m]) d_pk = int'(rr_m);
                    else if (bus.req_valid[!rr_m]) d_pk = int'(!rr_m);
                end
                d_exp = (d_pk < 0) ? 2'b00 : (2'b01 << d_pk);
                chk("req_ready", bus.req_ready, d_exp);
                chk("busy", busy, busy_m);
                d_hs = bus.req_valid & bus.req_ready;
                if (d_hs != 2'b00) begin
                    d_g = d_hs[1] ? 1 : 0;
                    d_e = predict(d_g, rq[d_g].pop_front(), cyc);
                    sb.push_back(d_e);
                    sq.push_back(d_e);
                    busy_m = 1'b1;
                    rr_m = (d_g == 0);
                end
            end
        end
    end

    // Behavioural AES core: start/done timing, wrong-op and level-done behaviour.
    exp_t c_cur;
    int   c_el = 0;
    bit   c_act = 1'b0;
    initial begin
        core_done_enc = 1'b0;
        core_done_dec = 1'b0;
        core_dout_enc = '0;
        core_dout_dec = '0;
        forever begin
            @(negedge clk);
            core_done_enc = 1'b0;
            core_done_dec = 1'b0;
            core_dout_enc = rnd128();
            core_dout_dec = rnd128();
            if (rst) begin
                c_act = 1'b0;
            end else if (core_start_enc || core_start_dec) begin
                if (sq.size() == 0) begin
                    total++;
                    $display("FAIL spurious_start: start=%b%b with no accepted request", core_start_enc, core_start_dec);
                    c_act = 1'b0;
                end else begin
                    c_cur = sq.pop_front();
                    chk("start_op", {core_start_enc, core_start_dec}, c_cur.r.op ? 2'b01 : 2'b10);
                    chk("start_time", cyc - c_cur.acc, 1);
                    chk("core_din", c_cur.r.op ? core_din_dec : core_din_enc, c_cur.r.data);
                    chk("core_key", core_key, c_cur.r.key);
                    c_act = 1'b1;
                    c_el = 0;
                end
            end else if (c_act) begin
                c_el++;
                if (c_cur.r.wrong && c_el == 1) begin
                    if (c_cur.r.op) core_done_enc = 1'b1;
                    else core_done_dec = 1'b1;
                end
                if (c_cur.r.delay != 0 && (c_el == c_cur.r.delay || (c_cur.r.level && c_el > c_cur.r.delay))) begin
                    if (c_cur.r.op) begin
                        core_done_dec = 1'b1;
                        core_dout_dec = fdec(c_cur.r.data, c_cur.r.key);
                    end else begin
                        core_done_enc = 1'b1;
                        core_dout_enc = fenc(c_cur.r.data, c_cur.r.key);
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response handshake happens.
    logic [1:0]    m_hs, prev_v;
    logic [DW-1:0] prev_d;
    logic          prev_e;
    exp_t          m_e;
    initial begin
        bus.rsp_ready = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.rsp_ready = 2'b00;
            end else begin
                if (hold_prev) begin
                    chk("rsp_hold_valid", bus.rsp_valid, prev_v);
                    chk("rsp_hold_data", bus.rsp_data, prev_d);
                    chk("rsp_hold_err", bus.rsp_err, prev_e);
                    hold_prev = 1'b0;
                end
                if (just_done) begin
                    chk("rsp_clear", {bus.rsp_err, bus.rsp_valid}, 0);
                    just_done = 1'b0;
                end
                if (bus.rsp_valid != 2'b00 && !in_rsp) begin
                    in_rsp = 1'b1;
                    hold_left = hold_cycles;
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL rsp_unexpected: rsp_valid=%b with no outstanding request", bus.rsp_valid);
                    end else begin
                        chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
                    end
                end
                if (hold_left > 0) begin
                    bus.rsp_ready = ~bus.rsp_valid;
                    hold_left--;
                end else if (rsp_rand) begin
                    bus.rsp_ready = 2'($urandom);
                end else begin
                    bus.rsp_ready = 2'b11;
                end
                #2;
                if (!rst && in_rsp) begin
                    m_hs = bus.rsp_valid & bus.rsp_ready;
                    if (m_hs != 2'b00) begin
                        if (sb.size() != 0) begin
                            m_e = sb.pop_front();
                            chk("rsp_port", bus.rsp_valid, 2'b01 << m_e.gid);
                            chk("rsp_data", bus.rsp_data, m_e.data);
                            chk("rsp_err", bus.rsp_err, m_e.err);
                        end
                        busy_m = 1'b0;
                        in_rsp = 1'b0;
                        just_done = 1'b1;
                    end else begin
                        hold_prev = 1'b1;
                        prev_v = bus.rsp_valid;
                        prev_d = bus.rsp_data;
                        prev_e = bus.rsp_err;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    int n;
    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        #2 rst = 1'b0;
        @(negedge clk);
        #3;

        // FIPS-197 C.1 encrypt from requester 0, core done 10 cycles after start.
        push(0, 1'b0, FIPS_PT, FIPS_KEY, 10, 1'b0, 1'b0);
        wait_idle(200, "fips");

        // Contention: both requesters continuously valid, four operations each.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'($urandom), rnd128(), rnd128(), $urandom_range(1, 12), 1'b0, 1'b0);
            push(1, 1'($urandom), rnd128(), rnd128(), $urandom_range(1, 12), 1'b0, 1'b0);
        end
        wait_idle(400, "contention");

        // Back-pressure: response held off for 20 cycles while the other requester waits.
        hold_cycles = 20;
        push(0, 1'b0, rnd128(), rnd128(), 3, 1'b0, 1'b0);
        push(1, 1'b1, rnd128(), rnd128(), 3, 1'b0, 1'b0);
        wait_idle(200, "backpressure");
        hold_cycles = 0;

        // Watchdog: hung core, done exactly at the limit, done one past the limit, then normal.
        push(1, 1'b0, rnd128(), rnd128(), 0, 1'b0, 1'b0);
        push(0, 1'b1, rnd128(), rnd128(), TO, 1'b0, 1'b0);
        push(1, 1'b0, rnd128(), rnd128(), TO + 1, 1'b0, 1'b0);
        push(0, 1'b0, rnd128(), rnd128(), 5, 1'b0, 1'b0);
        wait_idle(600, "timeout");

        // Decrypt with a stray encrypt-done before the real decrypt-done.
        push(0, 1'b1, rnd128(), rnd128(), 4, 1'b1, 1'b0);
        wait_idle(100, "wrong_op");

        // Randomized mix: requester, op, core latency, stray/level done, response back-pressure.
        rsp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r, dl;
            r = $urandom_range(0, 19);
            if (r == 0) dl = 0;
            else if (r == 1) dl = TO;
            else if (r == 2) dl = TO + 1;
            else dl = $urandom_range(1, 12);
            push($urandom_range(0, 1), 1'($urandom), rnd128(), rnd128(), dl,
                 (dl >= 3) && ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        wait_idle(8000, "random");
        rsp_rand = 1'b0;

        // Reset while waiting on a hung core, after a grant to requester 0.
        push(0, 1'b0, rnd128(), rnd128(), 0, 1'b0, 1'b0);
        n = 0;
        while (sb.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("midreset");
        rq[0].delete(); rq[1].delete(); sb.delete(); sq.delete();
        busy_m = 1'b0; rr_m = 1'b0; in_rsp = 1'b0; hold_prev = 1'b0;
        just_done = 1'b0; hold_left = 0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3 chk("post_reset_idle", {busy, bus.rsp_valid}, 0);
        end
        push(0, 1'b0, rnd128(), rnd128(), 2, 1'b0, 1'b0);
        push(1, 1'b1, rnd128(), rnd128(), 2, 1'b0, 1'b0);
        wait_idle(200, "post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES encrypt/decrypt core between two requesters (req0, req1) using round-robin arbitration.
- Accepts one operation at a time (encrypt or decrypt, with data and key) over a valid/ready channel.
- Sequences the core's start/done protocol and returns the result to the granted requester over a valid/ready response channel.
- Sits between the host-side request ports and the AES core; a watchdog converts a hung core into an error response.

Parameters:
- DATA_WIDTH, 128, width of data/key buses (matches core)
- TIMEOUT_CYCLES, 64, max cycles waiting for core done before error; must be >= 2
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; one-hot or zero
- req_op  in  2  bit i: 0 = encrypt, 1 = decrypt
- req_data0, req_data1  in  DATA_WIDTH  plaintext (enc) or ciphertext (dec)
- req_key0, req_key1  in  DATA_WIDTH  key
- rsp_valid  out  2  response valid, one-hot or zero
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  DATA_WIDTH  result, shared by both response ports
- rsp_err  out  1  1 = watchdog timeout; rsp_data = 0
- core_start_enc  out  1  one-cycle start pulse to core encryption
- core_start_dec  out  1  one-cycle start pulse to core decryption
- core_din_enc  out  DATA_WIDTH  plaintext to core
- core_din_dec  out  DATA_WIDTH  ciphertext to core
- core_key  out  DATA_WIDTH  key to core
- core_dout_enc  in  DATA_WIDTH  core ciphertext result
- core_dout_dec  in  DATA_WIDTH  core plaintext result
- core_done_enc  in  1  core encryption done (pulse or level)
- core_done_dec  in  1  core decryption done (pulse or level)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state = IDLE; rr_ptr = 0 (requester 0 has priority); registered operands = 0; watchdog = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = rr_ptr if req_valid[rr_ptr], else the other requester if it is valid.
  - req_ready[g] is asserted combinationally in IDLE only, so the handshake completes in this same cycle.
  - On handshake: latch op, data and key into registers; record g; rr_ptr <= ~g; go to ISSUE.
  - With no valid request, remain in IDLE.
- ISSUE (exactly 1 cycle):
  - Assert core_start_enc or core_start_dec per the latched op.
  - core_din_enc, core_din_dec and core_key are driven from registers, stable from ISSUE through WAIT.
  - Clear watchdog; go to WAIT.
- WAIT:
  - Watch only the done input matching the latched op; the other done input is ignored.
  - On the matching done: capture the matching core_dout into rsp_data; rsp_err = 0; go to RESP.
  - Otherwise increment the watchdog. When watchdog == TIMEOUT_CYCLES-1 with no done, set rsp_data = 0, rsp_err = 1, go to RESP.
  - If done arrives in the same cycle as the watchdog limit, done wins (rsp_err = 0).
- RESP:
  - rsp_valid[g] = 1; rsp_data and rsp_err are held stable.
  - On rsp_ready[g]: go to IDLE; rsp_valid and rsp_err clear next cycle.
  - rsp_ready on the non-granted bit is ignored.
- Latency: request handshake to rsp_valid = 2 + N cycles, where N is the number of WAIT cycles until done (N >= 1).
- No new request is accepted until the response handshake completes; throughput is one operation at a time.
- Fairness:
  - With both requesters continuously valid, grants alternate 0, 1, 0, 1, ...
  - A lone requester is granted back-to-back; rr_ptr still toggles to the non-granted requester.
- Level-type done: a done level held over from a previous operation must not complete the next one. Therefore done is only sampled in WAIT, which starts at least one cycle after the start pulse.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. No start pulse is issued after reset; the in-flight core result is discarded.

Test Plan:
- Single encrypt, req0: key 000102…0f, data 00112233…eeff (FIPS-197 C.1); core model returns done after 10 cycles -> core_start_enc pulses 1 cycle after accept; rsp_valid[0] 12 cycles after accept; rsp_data = 69c4e0d8…c55a; rsp_err = 0.
- Contention: both valid continuously, 4 operations each -> grant order 0,1,0,1,…; req_ready never 2'b11; each response goes only to its own requester.
- Back-pressure: hold rsp_ready = 0 for 20 cycles -> rsp_valid and rsp_data stable; req_ready stays 0 and core_start pulses are absent throughout.
- Timeout: core never asserts done, TIMEOUT_CYCLES = 64 -> RESP entered after 64 WAIT cycles with rsp_err = 1 and rsp_data = 0; next request processed normally.
- Wrong-op done: decrypt issued, core_done_enc pulses, then core_done_dec 3 cycles later -> completion only on core_done_dec; rsp_data = core_dout_dec.
- Reset asserted in WAIT -> outputs 0 immediately without a clock edge; FSM in IDLE; rr_ptr = 0; no stale rsp_valid after reset release.
